// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle.
//   master: requester/consumer side (drives in_valid, op, in_a, in_b, out_ready)
//   slave : ALU side (drives in_ready, out_valid, out, fault)
//   in_valid/in_ready   request handshake; op/in_a/in_b sampled on accept
//   out_valid/out_ready result handshake; out/fault qualified by out_valid
interface alu_multicycle_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [OP_WIDTH-1:0]   op;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out;
    logic                  fault;

    modport master (
        output in_valid, op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out, fault
    );

    modport slave (
        input  in_valid, op, in_a, in_b, out_ready,
        output in_ready, out_valid, out, fault
    );
endinterface

// File: rtl/alu_multicycle.sv
// Handshaked RV32I/E integer ALU. ADD/SUB/SLT/SLTU/XOR/OR/AND complete in one
// cycle; SLL/SRL/SRA shift iteratively, at most SHIFT_STEP bits per cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; drops any in-flight request
//   bus    alu_multicycle_if.slave: in_valid/in_ready/op/in_a/in_b request,
//          out_valid/out_ready/out/fault result (out/fault registered)
module alu_multicycle #(
    parameter int DATA_WIDTH  = 32,
    parameter int OP_WIDTH    = 4,
    parameter int SHIFT_STEP  = 1,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    alu_multicycle_if.slave  bus
);
    localparam int STEP_W = $clog2(SHIFT_STEP + 1);

    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(4'b0000);
    localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(4'b0001);
    localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(4'b0010);
    localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(4'b0011);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(4'b0100);
    localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(4'b0101);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(4'b0110);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(4'b0111);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(4'b1000);
    localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(4'b1101);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_t;

    state_t                 state_q, state_d;
    shkind_t                kind, kind_q;
    logic                   is_valid, is_shift;
    logic [DATA_WIDTH-1:0]  alu_res;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [SHAMT_WIDTH-1:0] rem_q, rem_next;
    logic [STEP_W-1:0]      step_amt;
    logic [DATA_WIDTH-1:0]  shreg_q, shifted;
    logic [DATA_WIDTH-1:0]  out_q;
    logic                   fault_q;

    assign shamt     = bus.in_b[SHAMT_WIDTH-1:0];
    assign bus.out   = out_q;
    assign bus.fault = fault_q;

    // Operation decode and single-cycle results.
    always_comb begin
        is_valid = 1'b1;
        is_shift = 1'b0;
        kind     = SH_LL;
        alu_res  = '0;
        case (bus.op)
            OP_ADD:  alu_res = bus.in_a + bus.in_b;
            OP_SUB:  alu_res = bus.in_a - bus.in_b;
            OP_SLT:  alu_res = DATA_WIDTH'($signed(bus.in_a) < $signed(bus.in_b));
            OP_SLTU: alu_res = DATA_WIDTH'(bus.in_a < bus.in_b);
            OP_XOR:  alu_res = bus.in_a ^ bus.in_b;
            OP_OR:   alu_res = bus.in_a | bus.in_b;
            OP_AND:  alu_res = bus.in_a & bus.in_b;
            OP_SLL:  begin is_shift = 1'b1; kind = SH_LL; end
            OP_SRL:  begin is_shift = 1'b1; kind = SH_RL; end
            OP_SRA:  begin is_shift = 1'b1; kind = SH_RA; end
            default: is_valid = 1'b0;
        endcase
    end

    // One shift step of min(rem, SHIFT_STEP) bits. The arithmetic shift keeps
    // the register MSB, which stays equal to the captured in_a sign bit.
    always_comb begin
        if (32'(rem_q) < SHIFT_STEP) step_amt = STEP_W'(rem_q);
        else                         step_amt = STEP_W'(SHIFT_STEP);
        rem_next = rem_q - SHAMT_WIDTH'(step_amt);
        case (kind_q)
            SH_LL:   shifted = shreg_q << step_amt;
            SH_RL:   shifted = shreg_q >> step_amt;
            SH_RA:   shifted = $signed(shreg_q) >>> step_amt;
            default: shifted = shreg_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid)
                    state_d = (is_valid && is_shift && shamt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                if (rem_q == '0) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            fault_q <= 1'b0;
            shreg_q <= '0;
            rem_q   <= '0;
            kind_q  <= SH_LL;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (!is_valid) begin
                            out_q   <= '0;
                            fault_q <= 1'b1;
                        end else if (!is_shift) begin
                            out_q   <= alu_res;
                            fault_q <= 1'b0;
                        end else if (shamt == '0) begin
                            out_q   <= bus.in_a;
                            fault_q <= 1'b0;
                        end else begin
                            shreg_q <= bus.in_a;
                            rem_q   <= shamt;
                            kind_q  <= kind;
                        end
                    end
                end
                SHIFT: begin
                    // Result is published on the cycle after rem hits zero.
                    if (rem_q == '0) begin
                        out_q   <= shreg_q;
                        fault_q <= 1'b0;
                    end else begin
                        shreg_q <= shifted;
                        rem_q   <= rem_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: four instances with SHIFT_STEP 1/4/8/32 share
// one request stream; each has its own out_ready so back-pressure and
// latency are checked per instance against a behavioural model.
module tb_alu_multicycle;
    localparam int N = 4;
    localparam int STEPV [N] = '{1, 4, 8, 32};

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  op;
    logic [31:0] in_a, in_b;
    logic [N-1:0] out_ready, vld, rdy, flt;
    logic [31:0] res [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        alu_multicycle_if #(.DATA_WIDTH(32), .OP_WIDTH(4)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.op        = op;
        assign bus.in_a      = in_a;
        assign bus.in_b      = in_b;
        assign bus.out_ready = out_ready[g];
        assign vld[g]        = bus.out_valid;
        assign rdy[g]        = bus.in_ready;
        assign flt[g]        = bus.fault;
        assign res[g]        = bus.out;
        alu_multicycle #(
            .DATA_WIDTH(32),
            .OP_WIDTH(4),
            .SHIFT_STEP(STEPV[g])
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {fault, result} from the instruction semantics.
    function automatic logic [32:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh = b[4:0];
        case (o)
            4'd0:  return {1'b0, a + b};
            4'd8:  return {1'b0, a - b};
            4'd2:  return {1'b0, 32'(($signed(a) < $signed(b)) ? 1 : 0)};
            4'd3:  return {1'b0, 32'((a < b) ? 1 : 0)};
            4'd4:  return {1'b0, a ^ b};
            4'd6:  return {1'b0, a | b};
            4'd7:  return {1'b0, a & b};
            4'd1:  return {1'b0, a << sh};
            4'd5:  return {1'b0, a >> sh};
            4'd13: return {1'b0, 32'($signed(a) >>> sh)};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] o, input logic [31:0] b, input int step);
        int sh = int'(b[4:0]);
        if ((o == 4'd1 || o == 4'd5 || o == 4'd13) && sh != 0)
            return 1 + (sh + step - 1) / step;
        return 1;
    endfunction

    // Issue one request, hold each instance's out_ready low for `hold` cycles
    // of out_valid, and check valid/ready/out/fault every cycle until idle.
    task automatic run_req(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
        int lat [N];
        int kmax = 0;
        logic [32:0] exp = model(o, a, b);
        for (int i = 0; i < N; i++) begin
            lat[i] = exp_lat(o, b, STEPV[i]);
            if (lat[i] + hold + 1 > kmax) kmax = lat[i] + hold + 1;
            check($sformatf("pre_rdy[%0d]", i), 32'(rdy[i]), 32'd1);
        end
        out_ready = '0;
        op = o; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= kmax; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (k <= lat[i] + hold + 1) begin
                    check($sformatf("vld[%0d] op=%0d k=%0d", i, o, k), 32'(vld[i]),
                          32'((k >= lat[i] && k <= lat[i] + hold) ? 1 : 0));
                    check($sformatf("rdy[%0d] op=%0d k=%0d", i, o, k), 32'(rdy[i]),
                          32'((k > lat[i] + hold) ? 1 : 0));
                end
                if (k == lat[i] || k == lat[i] + hold + 1) begin
                    check($sformatf("out[%0d] op=%0d a=%h b=%h k=%0d", i, o, a, b, k), res[i], exp[31:0]);
                    check($sformatf("fault[%0d] op=%0d k=%0d", i, o, k), 32'(flt[i]), 32'(exp[32]));
                end
                if (k == lat[i] + hold) out_ready[i] = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = '0;
        op = '0; in_a = '0; in_b = '0;
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_vld[%0d]", i), 32'(vld[i]), 32'd0);
            check($sformatf("rst_rdy[%0d]", i), 32'(rdy[i]), 32'd1);
            check($sformatf("rst_out[%0d]", i), res[i], 32'd0);
            check($sformatf("rst_fault[%0d]", i), 32'(flt[i]), 32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        run_req(4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 0);  // ADD wrap
        run_req(4'd13, 32'h8000_0000, 32'd4,         0);  // SRA by 4
        run_req(4'd1,  32'h0000_0001, 32'd31,        0);  // SLL by 31
        run_req(4'd1,  32'h1234_5678, 32'h20,        0);  // upper in_b bits ignored, shamt 0
        run_req(4'd15, 32'h1234_5678, 32'h9,         1);  // invalid op
        run_req(4'd2,  32'hFFFF_FFFF, 32'd1,         0);  // SLT
        run_req(4'd3,  32'hFFFF_FFFF, 32'd1,         0);  // SLTU
        run_req(4'd4,  32'hA5A5_0F0F, 32'h0FF0_FF00, 10); // back-pressure
        run_req(4'd13, 32'h8000_0001, 32'd31,        2);
        run_req(4'd5,  32'h8000_0001, 32'd31,        0);

        // Reset during a shift.
        out_ready = '0;
        op = 4'd5; in_a = 32'hF000_0000; in_b = 32'd16; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("mid_rst_vld[%0d]", i), 32'(vld[i]), 32'd0);
            check($sformatf("mid_rst_rdy[%0d]", i), 32'(rdy[i]), 32'd1);
            check($sformatf("mid_rst_out[%0d]", i), res[i], 32'd0);
            check($sformatf("mid_rst_fault[%0d]", i), 32'(flt[i]), 32'd0);
        end
        #2 reset = 1'b0;
        @(posedge clk); #1;
        run_req(4'd0, 32'h0000_1234, 32'h0000_4321, 0);

        for (int t = 0; t < 60; t++) begin
            logic [3:0]  ro = 4'($urandom_range(0, 15));
            logic [31:0] ra = pick_operand();
            logic [31:0] rb = pick_operand();
            run_req(ro, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end
endmodule
